// File: rtl/prco_sched_pkg.sv
// Shared types and constants for the prco instruction sequencer.
package prco_sched_pkg;

    // Opcodes of the prco ISA handled by the sequencer.
    localparam logic [4:0] PRCO_OP_NOP  = 5'h00;
    localparam logic [4:0] PRCO_OP_ADD  = 5'h01;
    localparam logic [4:0] PRCO_OP_MOV  = 5'h02;
    localparam logic [4:0] PRCO_OP_MOVI = 5'h03;
    localparam logic [4:0] PRCO_OP_LW   = 5'h04;
    localparam logic [4:0] PRCO_OP_SW   = 5'h05;

    // Instruction field bit positions.
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 11;
    localparam int RD_MSB    = 10;
    localparam int RD_LSB    = 8;
    localparam int RB_MSB    = 7;
    localparam int RB_LSB    = 5;
    localparam int IMM8_MSB  = 7;
    localparam int SIMM5_MSB = 4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    // Decoded view of the latched instruction.
    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rd;
        logic [2:0] rb;
        logic [7:0] imm8;
        logic [4:0] simm5;
        logic       alu_wb;
        logic       mem;
        logic       is_store;
        logic       nop;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/prco_decode.sv
// Combinational field extract and opcode classification.
module prco_decode
    import prco_sched_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] instr,
    output dec_t          dec
);

    // Split the instruction into fields and sort the opcode into its class.
    always_comb begin
        dec       = '0;
        dec.op    = instr[OP_MSB:OP_LSB];
        dec.rd    = instr[RD_MSB:RD_LSB];
        dec.rb    = instr[RB_MSB:RB_LSB];
        dec.imm8  = instr[IMM8_MSB:0];
        dec.simm5 = instr[SIMM5_MSB:0];
        case (instr[OP_MSB:OP_LSB])
            PRCO_OP_ADD, PRCO_OP_MOV, PRCO_OP_MOVI: dec.alu_wb = 1'b1;
            PRCO_OP_LW:                             dec.mem    = 1'b1;
            PRCO_OP_SW: begin
                dec.mem      = 1'b1;
                dec.is_store = 1'b1;
            end
            PRCO_OP_NOP:                            dec.nop     = 1'b1;
            default:                                dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/prco_sched.sv
// Multicycle sequencer: fetch handshake, RF reads, ALU enable, memory handshake, write-back.
module prco_sched
    import prco_sched_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_instr,
    input  logic          i_instr_valid,
    output logic          o_instr_ready,
    output logic [RW-1:0] o_rf_addr_a,
    output logic [RW-1:0] o_rf_addr_b,
    input  logic [DW-1:0] i_rf_data_a,
    input  logic [DW-1:0] i_rf_data_b,
    output logic          o_rf_we,
    output logic [RW-1:0] o_rf_waddr,
    output logic [DW-1:0] o_rf_wdata,
    output logic          o_alu_ce,
    output logic [4:0]    o_alu_op,
    output logic [7:0]    o_alu_imm8,
    output logic [4:0]    o_alu_simm5,
    input  logic [DW-1:0] i_alu_result,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy,
    output logic          o_illegal
);

    state_t        state_q, state_d;
    logic [DW-1:0] instr_q;
    logic [DW-1:0] sdata_q;
    logic [DW-1:0] ldata_q;
    logic [4:0]    alu_op_q;
    logic [7:0]    imm8_q;
    logic [4:0]    simm5_q;
    dec_t          dec;

    prco_decode #(.DW(DW)) u_decode (
        .instr (instr_q),
        .dec   (dec)
    );

    // rf data port b feeds the ALU directly; the sequencer never needs it.
    logic unused_rf_b;
    assign unused_rf_b = ^i_rf_data_b;

    // State register; async reset drops every state-derived strobe at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    // Instruction latch, ALU operand hold, store data and load data capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_q  <= '0;
            sdata_q  <= '0;
            ldata_q  <= '0;
            alu_op_q <= '0;
            imm8_q   <= '0;
            simm5_q  <= '0;
        end else begin
            if (state_q == ST_FETCH && i_instr_valid) instr_q <= i_instr;
            // Loaded on the way into EXEC so the ALU sees them during EXEC and after.
            if (state_q == ST_DECODE && !dec.illegal) begin
                alu_op_q <= dec.op;
                imm8_q   <= dec.imm8;
                simm5_q  <= dec.simm5;
            end
            if (state_q == ST_EXEC) sdata_q <= i_rf_data_a;
            if (state_q == ST_MEM && i_mem_ack && !dec.is_store) ldata_q <= i_mem_rdata;
        end
    end

    assign o_alu_op    = alu_op_q;
    assign o_alu_imm8  = imm8_q;
    assign o_alu_simm5 = simm5_q;
    assign o_busy      = (state_q != ST_FETCH);

    // Next-state and per-state output decode.
    always_comb begin
        state_d       = state_q;
        o_instr_ready = 1'b0;
        o_rf_addr_a   = '0;
        o_rf_addr_b   = '0;
        o_rf_we       = 1'b0;
        o_rf_waddr    = '0;
        o_rf_wdata    = '0;
        o_alu_ce      = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_illegal     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                o_rf_addr_a = dec.rd;
                o_rf_addr_b = dec.rb;
                o_illegal   = dec.illegal;
                state_d     = dec.illegal ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                o_alu_ce = 1'b1;
                if (dec.nop)      state_d = ST_FETCH;
                else if (dec.mem) state_d = ST_MEM;
                else              state_d = ST_WB;
            end
            ST_MEM: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_alu_result;
                o_mem_we   = dec.is_store;
                if (dec.is_store) o_mem_wdata = sdata_q;
                if (i_mem_ack) state_d = dec.is_store ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = dec.rd;
                o_rf_wdata = dec.mem ? ldata_q : i_alu_result;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_prco_sched.sv
// Directed bench for prco_sched with a small register-file and ALU model.
module tb_prco_sched;
    import prco_sched_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_instr = '0;
    logic        i_instr_valid = 1'b0;
    logic        o_instr_ready;
    logic [2:0]  o_rf_addr_a, o_rf_addr_b;
    logic [15:0] i_rf_data_a, i_rf_data_b;
    logic        o_rf_we;
    logic [2:0]  o_rf_waddr;
    logic [15:0] o_rf_wdata;
    logic        o_alu_ce;
    logic [4:0]  o_alu_op;
    logic [7:0]  o_alu_imm8;
    logic [4:0]  o_alu_simm5;
    logic [15:0] i_alu_result;
    logic        o_mem_req, o_mem_we;
    logic [15:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_rdata = '0;
    logic        o_busy, o_illegal;

    int cmp = 0;
    int errs = 0;

    prco_sched dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_instr(i_instr), .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .o_rf_addr_a(o_rf_addr_a), .o_rf_addr_b(o_rf_addr_b),
        .i_rf_data_a(i_rf_data_a), .i_rf_data_b(i_rf_data_b),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_alu_ce(o_alu_ce), .o_alu_op(o_alu_op), .o_alu_imm8(o_alu_imm8),
        .o_alu_simm5(o_alu_simm5), .i_alu_result(i_alu_result),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Register file model: synchronous read, write on strobe, bench preload port.
    logic [15:0] rf [0:7];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    always @(posedge i_clk) begin
        i_rf_data_a <= rf[o_rf_addr_a];
        i_rf_data_b <= rf[o_rf_addr_b];
        if (pl_en)        rf[pl_addr] <= pl_data;
        else if (o_rf_we) rf[o_rf_waddr] <= o_rf_wdata;
    end

    // ALU model: registered result, computed only when enabled.
    always @(posedge i_clk) begin
        if (o_alu_ce) begin
            case (o_alu_op)
                PRCO_OP_ADD:  i_alu_result <= i_rf_data_a + i_rf_data_b;
                PRCO_OP_MOV:  i_alu_result <= i_rf_data_b;
                PRCO_OP_MOVI: i_alu_result <= {8'h00, o_alu_imm8};
                PRCO_OP_LW, PRCO_OP_SW:
                    i_alu_result <= i_rf_data_b + {{11{o_alu_simm5[4]}}, o_alu_simm5};
                default:      i_alu_result <= i_alu_result;
            endcase
        end
    end

    // At most one of ALU enable, memory-request rise and write-back per cycle.
    logic req_prev = 1'b0;
    always @(negedge i_clk) begin
        int n;
        if (i_rst_n) begin
            n = int'(o_alu_ce) + int'(o_mem_req && !req_prev) + int'(o_rf_we);
            cmp++;
            if (n > 1) begin errs++; $display("FAIL exclusive_strobes: got %0d active want <=1", n); end
        end
        req_prev = o_mem_req;
    end

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic issue(input logic [15:0] ins);
        i_instr = ins; i_instr_valid = 1'b1;
        step();
        i_instr_valid = 1'b0;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        cmp++; if (o_instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", o_instr_ready); end
        cmp++; if ({o_busy, o_rf_we, o_alu_ce, o_mem_req, o_mem_we, o_illegal} !== 6'b0) begin
            errs++; $display("FAIL rst_strobes: got %b want 000000", {o_busy, o_rf_we, o_alu_ce, o_mem_req, o_mem_we, o_illegal}); end
        cmp++; if ({o_alu_op, o_alu_imm8, o_alu_simm5, o_mem_addr, o_rf_wdata} !== '0) begin
            errs++; $display("FAIL rst_buses: got nonzero want 0"); end
        @(negedge i_clk); i_rst_n = 1'b1;
        step();
        preload(3'd0, 16'h0000);
        preload(3'd1, 16'h0010);
        preload(3'd3, 16'hFFF0);
        preload(3'd5, 16'h0100);
        preload(3'd6, 16'h1234);
    endtask

    task automatic test_movi();
        cmp++; if (o_instr_ready !== 1'b1) begin errs++; $display("FAIL movi_ready0: got %b want 1", o_instr_ready); end
        issue({PRCO_OP_MOVI, 3'd2, 8'h5A});
        cmp++; if ({o_busy, o_instr_ready, o_alu_ce} !== 3'b100) begin errs++; $display("FAIL movi_t1: got %b want 100", {o_busy, o_instr_ready, o_alu_ce}); end
        cmp++; if (o_rf_addr_a !== 3'd2) begin errs++; $display("FAIL movi_addr_a: got %0d want 2", o_rf_addr_a); end
        step();
        cmp++; if ({o_alu_ce, o_alu_op, o_alu_imm8} !== {1'b1, PRCO_OP_MOVI, 8'h5A}) begin
            errs++; $display("FAIL movi_t2_alu: got %b %h %h want 1 03 5a", o_alu_ce, o_alu_op, o_alu_imm8); end
        step();
        cmp++; if ({o_rf_we, o_rf_waddr, o_rf_wdata, o_alu_ce} !== {1'b1, 3'd2, 16'h005A, 1'b0}) begin
            errs++; $display("FAIL movi_t3_wb: got we=%b waddr=%0d wdata=%h ce=%b want 1 2 005a 0", o_rf_we, o_rf_waddr, o_rf_wdata, o_alu_ce); end
        step();
        cmp++; if ({o_instr_ready, o_rf_we} !== 2'b10) begin errs++; $display("FAIL movi_t4_ready: got %b want 10", {o_instr_ready, o_rf_we}); end
        cmp++; if (o_alu_op !== PRCO_OP_MOVI) begin errs++; $display("FAIL movi_op_hold: got %h want %h", o_alu_op, PRCO_OP_MOVI); end
    endtask

    task automatic test_add();
        issue({PRCO_OP_ADD, 3'd1, 3'd3, 5'd0});
        cmp++; if ({o_rf_addr_a, o_rf_addr_b} !== {3'd1, 3'd3}) begin errs++; $display("FAIL add_addr: got %0d %0d want 1 3", o_rf_addr_a, o_rf_addr_b); end
        step();
        cmp++; if (o_alu_ce !== 1'b1) begin errs++; $display("FAIL add_ce: got %b want 1", o_alu_ce); end
        step();
        cmp++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 3'd1, 16'h0000}) begin
            errs++; $display("FAIL add_wb: got we=%b waddr=%0d wdata=%h want 1 1 0000", o_rf_we, o_rf_waddr, o_rf_wdata); end
        step();
        cmp++; if (o_instr_ready !== 1'b1) begin errs++; $display("FAIL add_ready: got %b want 1", o_instr_ready); end
    endtask

    // MOV with fetch holding valid throughout; the held word is only taken when ready.
    task automatic test_back_to_back();
        i_instr = {PRCO_OP_MOV, 3'd3, 3'd2, 5'd0}; i_instr_valid = 1'b1;
        step();
        cmp++; if ({o_busy, o_instr_ready} !== 2'b10) begin errs++; $display("FAIL b2b_t1: got %b want 10", {o_busy, o_instr_ready}); end
        step(); step();
        cmp++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 3'd3, 16'h005A}) begin
            errs++; $display("FAIL b2b_wb1: got we=%b waddr=%0d wdata=%h want 1 3 005a", o_rf_we, o_rf_waddr, o_rf_wdata); end
        step();
        cmp++; if (o_instr_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b want 1", o_instr_ready); end
        step();
        i_instr_valid = 1'b0;
        cmp++; if (o_busy !== 1'b1) begin errs++; $display("FAIL b2b_accept2: got busy=%b want 1", o_busy); end
        step(); step();
        cmp++; if ({o_rf_we, o_rf_wdata} !== {1'b1, 16'h005A}) begin errs++; $display("FAIL b2b_wb2: got we=%b wdata=%h want 1 005a", o_rf_we, o_rf_wdata); end
        step();
    endtask

    task automatic test_nop();
        issue({PRCO_OP_NOP, 11'd0});
        step();
        cmp++; if (o_alu_ce !== 1'b1) begin errs++; $display("FAIL nop_ce: got %b want 1", o_alu_ce); end
        step();
        cmp++; if ({o_instr_ready, o_rf_we, o_mem_req} !== 3'b100) begin errs++; $display("FAIL nop_t3: got %b want 100", {o_instr_ready, o_rf_we, o_mem_req}); end
    endtask

    task automatic test_lw();
        issue({PRCO_OP_LW, 3'd4, 3'd5, 5'h1E});
        step(); step();
        for (int i = 0; i < 3; i++) begin
            cmp++; if ({o_mem_req, o_mem_we, o_mem_addr, o_rf_we} !== {1'b1, 1'b0, 16'h00FE, 1'b0}) begin
                errs++; $display("FAIL lw_wait%0d: got req=%b we=%b addr=%h rfwe=%b want 1 0 00fe 0", i, o_mem_req, o_mem_we, o_mem_addr, o_rf_we); end
            step();
        end
        i_mem_ack = 1'b1; i_mem_rdata = 16'hBEEF; #1;
        cmp++; if ({o_mem_req, o_mem_addr} !== {1'b1, 16'h00FE}) begin errs++; $display("FAIL lw_ack_cycle: got req=%b addr=%h want 1 00fe", o_mem_req, o_mem_addr); end
        step();
        i_mem_ack = 1'b0; i_mem_rdata = 16'h0000; #1;
        cmp++; if ({o_rf_we, o_rf_waddr, o_rf_wdata, o_mem_req} !== {1'b1, 3'd4, 16'hBEEF, 1'b0}) begin
            errs++; $display("FAIL lw_wb: got we=%b waddr=%0d wdata=%h req=%b want 1 4 beef 0", o_rf_we, o_rf_waddr, o_rf_wdata, o_mem_req); end
        step();
        cmp++; if (o_instr_ready !== 1'b1) begin errs++; $display("FAIL lw_ready: got %b want 1", o_instr_ready); end
    endtask

    task automatic test_sw();
        issue({PRCO_OP_SW, 3'd6, 3'd0, 5'd4});
        step(); step();
        i_mem_ack = 1'b1; #1;
        cmp++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_rf_we} !== {1'b1, 1'b1, 16'h0004, 16'h1234, 1'b0}) begin
            errs++; $display("FAIL sw_mem: got req=%b we=%b addr=%h wdata=%h rfwe=%b want 1 1 0004 1234 0", o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_rf_we); end
        step();
        i_mem_ack = 1'b0; #1;
        cmp++; if ({o_instr_ready, o_rf_we, o_mem_req} !== 3'b100) begin errs++; $display("FAIL sw_ready: got %b want 100", {o_instr_ready, o_rf_we, o_mem_req}); end
    endtask

    task automatic test_illegal();
        issue({5'h1F, 11'd0});
        cmp++; if ({o_illegal, o_alu_ce, o_rf_we, o_mem_req} !== 4'b1000) begin
            errs++; $display("FAIL ill_t1: got %b want 1000", {o_illegal, o_alu_ce, o_rf_we, o_mem_req}); end
        step();
        cmp++; if ({o_instr_ready, o_illegal, o_alu_ce, o_rf_we, o_mem_req} !== 5'b10000) begin
            errs++; $display("FAIL ill_t2: got %b want 10000", {o_instr_ready, o_illegal, o_alu_ce, o_rf_we, o_mem_req}); end
    endtask

    task automatic test_reset_mid_mem();
        issue({PRCO_OP_SW, 3'd6, 3'd0, 5'd4});
        step(); step();
        cmp++; if ({o_mem_req, o_mem_we} !== 2'b11) begin errs++; $display("FAIL rmm_pre: got %b want 11", {o_mem_req, o_mem_we}); end
        #2 i_rst_n = 1'b0;
        #1;
        cmp++; if ({o_mem_req, o_mem_we, o_busy, o_instr_ready} !== 4'b0001) begin
            errs++; $display("FAIL rmm_async: got %b want 0001", {o_mem_req, o_mem_we, o_busy, o_instr_ready}); end
        @(negedge i_clk); i_rst_n = 1'b1;
        step();
        cmp++; if ({o_instr_ready, o_busy} !== 2'b10) begin errs++; $display("FAIL rmm_fetch: got %b want 10", {o_instr_ready, o_busy}); end
        for (int i = 0; i < 3; i++) begin
            cmp++; if ({o_rf_we, o_mem_req} !== 2'b00) begin errs++; $display("FAIL rmm_quiet%0d: got %b want 00", i, {o_rf_we, o_mem_req}); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_movi();
        test_add();
        test_back_to_back();
        test_nop();
        test_lw();
        test_sw();
        test_illegal();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
